sisc_fetch_unit: RTL and testbench

//  Program counter, instruction register and instruction-memory fetch sequencer for the SISC core.

---
 rtl/sisc_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_sisc_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: program counter, instruction register and imem fetch sequencer.
// The control FSM issues pc_rst / pc_write / pc_sel / br_sel / ir_load commands.
// Instruction memory answers over a req/ack handshake, so fetch latency varies.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT_CYC
// cycles without ack. The abandoned fetch loads a NOOP into IR and sets fetch_err.
//
//   state  | meaning
//   IDLE   | no fetch outstanding; ir_load starts one from the current PC
//   REQ    | imem_req held high with a latched address, waiting for imem_ack
module sisc_fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              pc_rst,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic              br_sel,
    input  logic              ir_load,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [ADDR_W-1:0] imm,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    if ((ADDR_W < 8) || (ADDR_W > 16) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("sisc_fetch_unit: ADDR_W must be 8..16 and TIMEOUT_CYC at least 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc_q, pc_nx;
    logic [31:0]         ir_q, ir_nx;
    logic                req_q, req_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic                done_q, done_nx;
    logic [ADDR_W-1:0]   target;

`ifdef FETCH_TIMEOUT_EN
    // Down-counter loaded on REQ entry; reaching zero without ack is the timeout.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                err_q, err_nx;

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nx;
            err_q <= err_nx;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // State, PC, IR and handshake registers.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state  <= S_IDLE;
            pc_q   <= '0;
            ir_q   <= 32'h0;
            req_q  <= 1'b0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            ir_q   <= ir_nx;
            req_q  <= req_nx;
            addr_q <= addr_nx;
            done_q <= done_nx;
        end
    end

    // Branch target from the pre-edge PC and the current IR immediate. The
    // immediate is already ADDR_W wide, so sign extension is the identity and
    // the modular add covers both directions.
    always_comb begin
        target = br_sel ? (pc_q + ir_q[ADDR_W-1:0]) : ir_q[ADDR_W-1:0];
    end

    // Next-state logic: PC update and fetch sequencing.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        ir_nx    = ir_q;
        req_nx   = req_q;
        addr_nx  = addr_q;
        done_nx  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_nx   = cnt_q;
        err_nx   = pc_rst ? 1'b0 : err_q;
`endif

        if (pc_rst) begin
            pc_nx = '0;
        end else if (pc_write) begin
            pc_nx = pc_sel ? target : (pc_q + 1'b1);
        end

        case (state)
            S_IDLE: begin
                if (ir_load) begin
                    addr_nx  = pc_q;
                    req_nx   = 1'b1;
                    state_nx = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_nx   = CNT_W'(TIMEOUT_CYC - 1);
`endif
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    ir_nx    = imem_rdata;
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    ir_nx    = 32'h0;
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_nx = S_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign pc         = pc_q;
    assign instr      = ir_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign imm        = ir_q[ADDR_W-1:0];
    assign fetch_busy = (state == S_REQ);
    assign fetch_done = done_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: directed scenarios with literal expectations plus
// randomized commands/acks, all checked every cycle against a transaction model.
module tb_sisc_fetch_unit;
    localparam int AW  = 16;
    localparam int MOD = 65536;
    localparam int TO  = 15;

    logic          clk = 1'b0;
    logic          rst_f = 1'b0;
    logic          pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
    logic          ir_load = 1'b0, imem_ack = 1'b0;
    logic [31:0]   imem_rdata = 32'h0;
    logic          imem_req, fetch_busy, fetch_done, fetch_err;
    logic [AW-1:0] imem_addr, pc, imm;
    logic [31:0]   instr;
    logic [3:0]    opcode, mm;

    int n_vec = 0;
    int n_mis = 0;

    // Model: PC as a plain integer, the IR word, and one outstanding fetch record.
    int          m_pc = 0;
    logic [31:0] m_ir = 32'h0;
    bit          m_pend = 1'b0;
    int          m_addr = 0;
    int          m_wait = 0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    sisc_fetch_unit #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .opcode(opcode),
        .mm(mm), .imm(imm), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int imm_u, imm_s, new_pc;
        imm_u  = int'(m_ir[AW-1:0]);
        imm_s  = (imm_u >= MOD / 2) ? imm_u - MOD : imm_u;
        new_pc = m_pc;
        if (pc_rst) new_pc = 0;
        else if (pc_write) begin
            if (!pc_sel)     new_pc = (m_pc + 1) % MOD;
            else if (!br_sel) new_pc = imm_u;
            else             new_pc = (((m_pc + imm_s) % MOD) + MOD) % MOD;
        end
        m_done = 1'b0;
        if (pc_rst) m_err = 1'b0;
        if (m_pend) begin
            if (imem_ack) begin
                m_ir = imem_rdata; m_pend = 1'b0; m_done = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_ir = 32'h0; m_pend = 1'b0; m_done = 1'b1; m_err = 1'b1;
                end
            end
`endif
        end else if (ir_load) begin
            m_pend = 1'b1; m_addr = m_pc; m_wait = 0;
        end
        m_pc = new_pc;
    endtask

    // Advance the model on each edge (or reset it), then compare shortly after.
    always begin
        @(posedge clk or negedge rst_f);
        if (!rst_f) begin
            m_pc = 0; m_ir = 32'h0; m_pend = 1'b0; m_addr = 0;
            m_wait = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            model_edge();
        end
        #2;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr", instr, m_ir);
        chk("opcode", 32'(opcode), 32'(m_ir[31:28]));
        chk("mm", 32'(mm), 32'(m_ir[27:24]));
        chk("imm", 32'(imm), 32'(m_ir[AW-1:0]));
        chk("imem_req", 32'(imem_req), 32'(m_pend));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_pend));
        chk("fetch_done", 32'(fetch_done), 32'(m_done));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_pend || !rst_f) chk("imem_addr", 32'(imem_addr), 32'(m_pend ? m_addr : 0));
    end

    // Apply one cycle of inputs at the falling edge and return at the next one.
    task automatic drive(input bit pr, input bit pw, input bit ps, input bit bs,
                         input bit il, input bit ack, input logic [31:0] rd);
        pc_rst = pr; pc_write = pw; pc_sel = ps; br_sel = bs;
        ir_load = il; imem_ack = ack; imem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic set_pc(input int v);
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < v; i++) drive(0, 1, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic quick_fetch(input logic [31:0] rd);
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 1, rd);
        idle(1);
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        idle(2);

        // Fetch from PC=3 with ack in the fourth REQ cycle.
        set_pc(3);
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(imem_req), 32'h1);
            chk("t2_addr", 32'(imem_addr), 32'h3);
            drive(0, 0, 0, 0, 0, 0, 32'h0);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h8100_0005);
        chk("t2_done", 32'(fetch_done), 32'h1);
        chk("t2_opcode", 32'(opcode), 32'h8);
        chk("t2_mm", 32'(mm), 32'h1);
        chk("t2_imm", 32'(imm), 32'h5);
        idle(1);
        chk("t2_done_width", 32'(fetch_done), 32'h0);

        // Relative then absolute branches.
        quick_fetch(32'h0000_FFFC);
        set_pc(10);
        drive(0, 1, 1, 1, 0, 0, 32'h0);
        chk("t3_rel", 32'(pc), 32'h6);
        quick_fetch(32'h0000_0020);
        drive(0, 1, 1, 0, 0, 0, 32'h0);
        chk("t3_abs", 32'(pc), 32'h20);

        // Wrap at all-ones and pc_rst priority.
        quick_fetch(32'h0000_FFFF);
        drive(0, 1, 1, 0, 0, 0, 32'h0);
        chk("t4_ffff", 32'(pc), 32'hFFFF);
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        chk("t4_wrap", 32'(pc), 32'h0);
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        chk("t4_prio", 32'(pc), 32'h0);

        // Overlapping ir_load and PC write during REQ; stray ack in IDLE.
        set_pc(7);
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 1, 0, 32'h0);
        chk("t5_addr", 32'(imem_addr), 32'h7);
        chk("t5_pc", 32'(pc), 32'h8);
        drive(0, 0, 0, 0, 0, 1, 32'hA5A5_1234);
        chk("t5_instr", instr, 32'hA5A5_1234);
        idle(1);
        chk("t5_single", 32'(imem_req), 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t5_stray", instr, 32'hA5A5_1234);
        chk("t5_stray_done", 32'(fetch_done), 32'h0);

        // Asynchronous reset in the middle of a fetch.
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        #2 rst_f = 1'b0;
        #1;
        chk("t1_req", 32'(imem_req), 32'h0);
        chk("t1_pc", 32'(pc), 32'h0);
        chk("t1_instr", instr, 32'h0);
        chk("t1_done", 32'(fetch_done), 32'h0);
        ir_load = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        idle(2);

`ifdef FETCH_TIMEOUT_EN
        // No ack: request must drop after exactly TO REQ cycles.
        quick_fetch(32'h1234_5678);
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!imem_req) break;
            cnt++;
            idle(1);
        end
        chk("t6_req_cycles", 32'(cnt), 32'(TO));
        chk("t6_instr", instr, 32'h0);
        chk("t6_err", 32'(fetch_err), 32'h1);
        chk("t6_done", 32'(fetch_done), 32'h1);
        idle(3);
        chk("t6_sticky", 32'(fetch_err), 32'h1);
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        chk("t6_clear", 32'(fetch_err), 32'h0);
`else
        cnt = 0;
`endif

        // Randomized commands; the second half makes acks rare.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 16) == 0, ($urandom % 3) == 0, $urandom % 2, $urandom % 2,
                  ($urandom % 4) == 0,
                  (i < 1500) ? (($urandom % 3) == 0) : (($urandom % 25) == 0),
                  $urandom);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
